// File: rtl/bram_stream_reader.sv
// Burst reader for a 1-cycle-latency BRAM: reads LEN words from BASE and
// emits them as a valid/ready stream through a 2-entry skid buffer.
module bram_stream_reader #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   iss_cnt;
    logic [CW-1:0]   emit_cnt;
    logic            rd_pend;
    logic            v0, v1;
    logic [DW-1:0]   d0, d1;

    logic            pop;
    logic            cap;
    logic            last_issue;
    logic            last_emit;
    logic [1:0]      occ_eff;

    assign pop        = v0 && out_ready;
    assign cap        = rd_pend;
    assign last_issue = (iss_cnt == len_q - CW'(1));
    assign last_emit  = (emit_cnt == len_q - CW'(1));

    // Entries still claiming a buffer slot once this cycle's pop retires.
    assign occ_eff    = 2'(v0) + 2'(v1) + 2'(rd_pend) - 2'(pop);

    // Read enable sees the current pop so a ready sink gets one word per clock.
    assign rd_en      = (state == RUN) && (occ_eff < 2'd2);

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign out_valid  = v0;
    assign out_data   = d0;
    assign out_last   = v0 && last_emit;

    // Burst control, address generation and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            iss_cnt  <= '0;
            emit_cnt <= '0;
            rd_addr  <= '0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (pop) begin
                emit_cnt <= emit_cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= length;
                        rd_addr  <= base_addr;
                        iss_cnt  <= '0;
                        emit_cnt <= '0;
                        state    <= (length == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr + AW'(1);
                        iss_cnt <= iss_cnt + CW'(1);
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_emit) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid buffer: entry 0 is the stream head, entry 1 holds the overflow word.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            case ({pop, cap})
                2'b11: begin
                    if (v1) begin
                        d0 <= d1;
                        d1 <= rd_data;
                    end else begin
                        d0 <= rd_data;
                    end
                end
                2'b10: begin
                    d0 <= d1;
                    v0 <= v1;
                    v1 <= 1'b0;
                end
                2'b01: begin
                    if (!v0) begin
                        d0 <= rd_data;
                        v0 <= 1'b1;
                    end else begin
                        d1 <= rd_data;
                        v1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 1-cycle-latency BRAM model
// holding mem[i] = i.
module tb_bram_stream_reader;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 24;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    logic [DW-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    bram_stream_reader #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_rd_en"},     32'(rd_en),     32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready = 1,0,1,0,... per cycle
    task automatic run_burst(input int base, input int len, input int mode);
        int            n;
        int            issued;
        int            first_v;
        int            last_hs;
        int            done_c;
        int            limit;
        bit            got_done;
        bit            prev_stall;
        logic [DW-1:0] prev_d;
        n = 0; issued = 0; first_v = -1; last_hs = -1; done_c = -1;
        got_done = 1'b0; prev_stall = 1'b0; prev_d = '0;
        limit = 2 * len + 20;
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            if (c > 1) @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : ((c % 2) == 1);
            #1;
            check("busy", 32'(busy), 32'd1);
            if (prev_stall) check("stall_data", 32'(out_data), 32'(prev_d));
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'((base + issued) % DEPTH));
                issued++;
            end
            if (out_valid && first_v < 0) first_v = c;
            if (out_valid && out_ready) begin
                check("data", 32'(out_data), 32'((base + n) % DEPTH));
                check("last", 32'(out_last), 32'(n == len - 1));
                n++;
                if (n == len) last_hs = c;
            end
            check("outstanding", 32'(issued - n <= 2), 32'd1);
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if (done) begin
                done_c   = c;
                got_done = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("words", 32'(n), 32'(len));
        check("reads", 32'(issued), 32'(len));
        if (len == 0) begin
            check("len0_done_lat", 32'(done_c), 32'd1);
            check("len0_no_valid", 32'(first_v), 32'hffff_ffff);
        end else begin
            check("first_valid", 32'(first_v), 32'd3);
            check("done_lat", 32'(done_c), 32'(last_hs + 1));
            if (mode == 0) check("throughput", 32'(last_hs), 32'(len + 2));
        end
        @(negedge clk);
        #1;
        check("post_busy", 32'(busy), 32'd0);
        check("post_done", 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        run_burst(0, 4, 0);
        run_burst(0, 4, 1);
        run_burst(1022, 4, 0);
        run_burst(0, 0, 0);
        run_burst(5, 1024, 0);

        // Reset mid-burst with a stalled sink, then a clean short burst.
        @(negedge clk);
        start = 1'b1; base_addr = '0; length = (AW+1)'(8); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_busy",  32'(busy),      32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("midrst");
        rst = 1'b0;
        run_burst(0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
